prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameters SHALL be: INST_BYTES (default 4), instruction size in bytes; MEM_BYTES (default 1), bytes returned per memory beat; DEPTH (default 4), queue entries; RESET_PC (default 32'h0), first fetch address.
REQ-002 i_clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 i_rst  in  1  reset; synchronous, active-high.
REQ-004 i_redirect  in  1  flush the queue and restart fetch at i_redirect_pc.
REQ-005 i_redirect_pc  in  32  new fetch address.
REQ-006 o_mem_req  out  1  memory beat request.
REQ-007 o_mem_addr  out  32  byte address of the requested beat.
REQ-008 i_mem_valid  in  1  the requested beat is present on i_mem_data.
REQ-009 i_mem_data  in  MEM_BYTES*8  beat data; byte 0 is bits [7:0].
REQ-010 o_inst_valid  out  1  the queue head is valid.
REQ-011 o_inst  out  INST_BYTES*8  queue head instruction.
REQ-012 o_inst_pc  out  32  address of o_inst.
REQ-013 i_inst_ready  in  1  consumer accepts the head when high together with o_inst_valid.

Function
REQ-014 MEM_BYTES SHALL divide INST_BYTES; DEPTH SHALL be a power of 2 and at least 2; the block SHALL fail elaboration otherwise.
REQ-015 BEATS = INST_BYTES/MEM_BYTES beats SHALL assemble one instruction; a beat counter SHALL run from 0 to BEATS-1 and wrap to 0.
REQ-016 Assembly SHALL be big-endian: the lowest-address byte lands in the most significant byte of o_inst.
REQ-017 o_mem_addr SHALL equal fetch_pc + beat*MEM_BYTES and SHALL hold stable while o_mem_req is high and i_mem_valid is low.
REQ-018 At most one beat SHALL be outstanding; a beat completes in any cycle with o_mem_req and i_mem_valid both high, latency 0 or more cycles.
REQ-019 The FSM SHALL have the states FETCH (o_mem_req=1), FULL (o_mem_req=0) and DISCARD (o_mem_req=0, awaiting a stale beat).
REQ-020 FETCH -> FULL SHALL occur when the last beat completes and the queue becomes full in that cycle; FULL -> FETCH SHALL occur on the cycle after a pop.
REQ-021 On the last beat, {assembled instruction, fetch_pc} SHALL be pushed; fetch_pc SHALL advance by INST_BYTES, wrapping modulo 2^32.
REQ-022 A push and a pop in the same cycle SHALL both succeed, including when the queue is full; the occupancy then stays unchanged.
REQ-023 A pop SHALL occur only when o_inst_valid and i_inst_ready are both high; o_inst and o_inst_pc SHALL be stable while o_inst_valid is high and no pop occurs.
REQ-024 The first instruction SHALL appear on o_inst_valid one cycle after its last beat completes.
REQ-025 i_redirect SHALL take priority over push and pop in the same cycle. It SHALL empty the queue, zero the beat counter and partial assembly, and set fetch_pc = i_redirect_pc with bits [log2(INST_BYTES)-1:0] forced to 0.
REQ-026 A redirect SHALL enter DISCARD if o_mem_req is high and i_mem_valid is low in that cycle, otherwise FETCH. In DISCARD, the next i_mem_valid SHALL be dropped and the state SHALL return to FETCH.
REQ-027 A redirect during DISCARD SHALL update fetch_pc and SHALL remain in DISCARD.

Reset
REQ-028 On reset, state SHALL be FETCH, fetch_pc RESET_PC, beat 0, and the queue empty; o_inst_valid SHALL be 0, o_mem_req 1 (from the first cycle after reset), and o_mem_addr RESET_PC.
REQ-029 Reset SHALL override redirect and any in-flight beat, with no DISCARD after reset; queue data storage SHALL need no reset.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum, INST_BYTES and RESET_PC defaults, and the clog2-derived width constants.
REQ-031 Storage SHALL be a sub-module inst_fifo (synchronous FIFO, parameters WIDTH and DEPTH, with flush input, push/pop and full/empty); the top level SHALL hold the FSM, the beat assembly and fetch_pc.

Verification
REQ-032 Defaults, memory returns bytes 0x11,0x22,0x33,0x44 at address 0..3 with zero latency, consumer always ready -> o_inst=0x11223344, o_inst_pc=0, valid on cycle 5 after reset release.
REQ-033 MEM_BYTES=2, i_mem_data 0x2211 then 0x4433 -> o_inst=0x11223344 and two beats at addresses 0 and 2.
REQ-034 Consumer never ready, DEPTH=4 -> exactly 4 pushes, state FULL, o_mem_req=0 and o_mem_addr=16; one pop -> o_mem_req returns the next cycle.
REQ-035 Redirect to 0x103 while beat at 0x1 is outstanding with i_mem_valid delayed 3 cycles -> the stale beat is dropped, the next request is at 0x100, and the first o_inst_pc is 0x100.
REQ-036 Full queue with push, pop and redirect in one cycle -> next cycle o_inst_valid=0, queue empty, fetch_pc equal to the redirect pc.
REQ-037 RESET_PC=32'hFFFFFFFC -> the second o_inst_pc is 0x00000000 (wrap-around).

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction prefetch
//                queue: fetch FSM state encoding, default instruction size
//                and reset PC, and clog2-derived width constants.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Address width of the fetch path
    localparam int unsigned c_PC_W         = 32;

    // Default instruction geometry and reset PC
    localparam int unsigned c_INST_BYTES   = 4;
    localparam logic [31:0] c_RESET_PC     = 32'h0000_0000;
    localparam int unsigned c_DEPTH        = 4;

    // Widths derived from the defaults
    localparam int unsigned c_INST_W       = c_INST_BYTES * 8;
    localparam int unsigned c_ALIGN_W      = $clog2(c_INST_BYTES);
    localparam int unsigned c_PTR_W        = $clog2(c_DEPTH);
    localparam int unsigned c_CNT_W        = $clog2(c_DEPTH) + 1;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,   // requesting beats
        ST_FULL    = 2'd1,   // queue full, request idle
        ST_DISCARD = 2'd2    // waiting to drop a beat issued before a redirect
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fifo
//  Description : Synchronous FIFO with flush. A push is accepted while full
//                if a pop happens in the same cycle. Head data is read
//                straight from storage, so it is valid the cycle after push.
//  Revision    : 1.0  initial release
// ============================================================================
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("inst_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_full    = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy tracking; flush wins over push and pop
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_queue
//  Description : Instruction prefetcher. Fetches instructions beat by beat
//                from memory (one beat outstanding), assembles them
//                big-endian and queues {instruction, pc} for a consumer.
//                A redirect flushes the queue and restarts at a new PC; a
//                beat already requested when the redirect arrives is dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned INST_BYTES = c_INST_BYTES,
    parameter int unsigned MEM_BYTES  = 1,
    parameter int unsigned DEPTH      = c_DEPTH,
    parameter logic [31:0] RESET_PC   = c_RESET_PC
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_redirect,
    input  logic [31:0]             i_redirect_pc,
    output logic                    o_mem_req,
    output logic [31:0]             o_mem_addr,
    input  logic                    i_mem_valid,
    input  logic [MEM_BYTES*8-1:0]  i_mem_data,
    output logic                    o_inst_valid,
    output logic [INST_BYTES*8-1:0] o_inst,
    output logic [31:0]             o_inst_pc,
    input  logic                    i_inst_ready
);

    localparam int unsigned c_BEATS     = INST_BYTES / MEM_BYTES;
    localparam int unsigned c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int unsigned c_I_W       = INST_BYTES * 8;
    localparam int unsigned c_M_W       = MEM_BYTES * 8;
    localparam int unsigned c_ASM_W     = (c_BEATS > 1) ? (c_I_W - c_M_W) : 1;
    localparam int unsigned c_ENTRY_W   = c_I_W + c_PC_W;
    localparam int unsigned c_Q_CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned c_I_ALIGN_W = $clog2(INST_BYTES);
    localparam logic [31:0] c_ALIGN_MASK  = ~((32'd1 << c_I_ALIGN_W) - 32'd1);
    localparam logic [c_BEAT_W-1:0]  c_LAST_BEAT   = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_Q_CNT_W-1:0] c_ALMOST_FULL = c_Q_CNT_W'(DEPTH - 1);

    if ((MEM_BYTES == 0) || ((INST_BYTES % MEM_BYTES) != 0)) begin : g_bad_mem_bytes
        $error("prefetch_queue: MEM_BYTES must divide INST_BYTES");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("prefetch_queue: DEPTH must be a power of 2 and at least 2");
    end

    fetch_state_e           r_state;
    fetch_state_e           w_state_nxt;
    logic [31:0]            r_fetch_pc;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [c_ASM_W-1:0]     r_asm;
    logic [c_M_W-1:0]       w_beat_be;
    logic [c_I_W-1:0]       w_asm_word;
    logic                   w_beat_done;
    logic                   w_last_beat;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fills;
    logic                   w_full;
    logic                   w_empty;
    logic [c_Q_CNT_W-1:0]   w_count;
    logic [c_ENTRY_W-1:0]   w_head;

    // Byte-reverse the beat: its lowest-address byte becomes the most significant
    for (genvar m = 0; m < int'(MEM_BYTES); m++) begin : g_swap
        assign w_beat_be[(int'(MEM_BYTES) - 1 - m)*8 +: 8] = i_mem_data[m*8 +: 8];
    end

    // Earlier beats sit above the current one, giving big-endian order
    if (c_BEATS > 1) begin : g_multi_beat
        assign w_asm_word = {r_asm, w_beat_be};
    end else begin : g_single_beat
        assign w_asm_word = w_beat_be;
    end

    assign w_beat_done  = (r_state == ST_FETCH) && i_mem_valid;
    assign w_last_beat  = (r_beat == c_LAST_BEAT);
    assign w_pop        = o_inst_valid && i_inst_ready && !i_redirect;
    assign w_push       = w_beat_done && w_last_beat && !i_redirect && (!w_full || w_pop);
    assign w_fills      = w_push && !w_pop && (w_count == c_ALMOST_FULL);
    assign o_mem_addr   = r_fetch_pc + (32'(r_beat) * 32'(MEM_BYTES));
    assign o_inst_valid = !w_empty;
    assign o_inst       = w_head[c_ENTRY_W-1 -: c_I_W];
    assign o_inst_pc    = w_head[c_PC_W-1:0];

    // Next-state and request logic; redirect overrides all other transitions
    always_comb begin
        w_state_nxt = r_state;
        o_mem_req   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_mem_req = 1'b1;
                if (w_fills) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (i_mem_valid) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
        if (i_redirect) begin
            if (r_state == ST_DISCARD) begin
                // Still owed a stale beat unless it lands in this very cycle,
                // in which case waiting longer would stall with no request out
                w_state_nxt = i_mem_valid ? ST_FETCH : ST_DISCARD;
            end else if ((r_state == ST_FETCH) && !i_mem_valid) begin
                w_state_nxt = ST_DISCARD;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC, beat counter and partial assembly
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_beat     <= '0;
            r_asm      <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= i_redirect_pc & c_ALIGN_MASK;
            r_beat     <= '0;
            r_asm      <= '0;
        end else if (w_beat_done) begin
            if (w_last_beat) begin
                r_fetch_pc <= r_fetch_pc + 32'(INST_BYTES);
                r_beat     <= '0;
                r_asm      <= '0;
            end else begin
                r_beat     <= r_beat + 1'b1;
                r_asm      <= w_asm_word[c_ASM_W-1:0];
            end
        end
    end

    inst_fifo #(
        .WIDTH   (c_ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_inst_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_data  ({w_asm_word, r_fetch_pc}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prefetch_queue
//  Description : Directed self-checking bench for prefetch_queue. Main DUT
//                uses defaults; two extra instances cover 2-byte beats and
//                PC wrap-around. Memory byte at address a is ((a+1)*0x11)
//                modulo 256; expected queue entries live in a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prefetch_queue;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Main DUT (defaults)
    logic        redir;
    logic [31:0] redir_pc;
    logic        mreq1;
    logic [31:0] maddr1;
    logic        mval1;
    logic [7:0]  mdata1;
    logic        ival1;
    logic [31:0] inst1;
    logic [31:0] ipc1;
    logic        rdy1;
    logic        manual1;
    logic        man_v1;
    int          lat1;
    int          wcnt1;

    // 2-byte beat DUT
    logic        mreq2;
    logic [31:0] maddr2;
    logic [15:0] mdata2;
    logic        ival2;
    logic [31:0] inst2;
    logic [31:0] ipc2;

    // Wrap-around DUT
    logic        mreq3;
    logic [31:0] maddr3;
    logic [7:0]  mdata3;
    logic        ival3;
    logic [31:0] inst3;
    logic [31:0] ipc3;

    int          total = 0;
    int          bad   = 0;
    int          pops1 = 0;
    int          cnt2  = 0;
    int          cnt3  = 0;
    logic [31:0] inst2_1, pc2_1, pc3_1, pc3_2, inst3_2;
    ent_t        sb_q[$];

    function automatic logic [7:0] fb(input logic [31:0] a);
        logic [7:0] lo;
        lo = a[7:0] + 8'd1;
        return 8'(lo * 8'd17);
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return {fb(pc), fb(pc + 32'd1), fb(pc + 32'd2), fb(pc + 32'd3)};
    endfunction

    assign mdata1 = fb(maddr1);
    assign mval1  = manual1 ? man_v1 : (mreq1 && (wcnt1 >= lat1));
    assign mdata2 = {fb(maddr2 + 32'd1), fb(maddr2)};
    assign mdata3 = fb(maddr3);

    always @(posedge clk) begin
        if (rst || redir || !mreq1 || mval1) wcnt1 <= 0;
        else                                 wcnt1 <= wcnt1 + 1;
    end

    prefetch_queue u_dut (
        .i_clk(clk), .i_rst(rst), .i_redirect(redir), .i_redirect_pc(redir_pc),
        .o_mem_req(mreq1), .o_mem_addr(maddr1), .i_mem_valid(mval1), .i_mem_data(mdata1),
        .o_inst_valid(ival1), .o_inst(inst1), .o_inst_pc(ipc1), .i_inst_ready(rdy1)
    );

    prefetch_queue #(.MEM_BYTES(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_redirect(1'b0), .i_redirect_pc(32'h0),
        .o_mem_req(mreq2), .o_mem_addr(maddr2), .i_mem_valid(mreq2), .i_mem_data(mdata2),
        .o_inst_valid(ival2), .o_inst(inst2), .o_inst_pc(ipc2), .i_inst_ready(1'b1)
    );

    prefetch_queue #(.RESET_PC(32'hFFFF_FFFC)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_redirect(1'b0), .i_redirect_pc(32'h0),
        .o_mem_req(mreq3), .o_mem_addr(maddr3), .i_mem_valid(mreq3), .i_mem_data(mdata3),
        .o_inst_valid(ival3), .o_inst(inst3), .o_inst_pc(ipc3), .i_inst_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_reload(input logic [31:0] start, input int n);
        ent_t        e;
        logic [31:0] pc;
        sb_q.delete();
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.inst = exp_inst(pc);
            e.pc   = pc;
            sb_q.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    // Compare any pop about to happen, record side-DUT outputs, advance one cycle
    task automatic cyc();
        ent_t e;
        if (!rst && !redir && ival1 && rdy1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected_inst observed_pc=%0h expected=none", ipc1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_inst", 64'(inst1), 64'(e.inst));
                chk("sb_pc", 64'(ipc1), 64'(e.pc));
                pops1++;
            end
        end
        if (!rst && ival3) begin
            cnt3++;
            if (cnt3 == 1) pc3_1 = ipc3;
            if (cnt3 == 2) begin
                pc3_2   = ipc3;
                inst3_2 = inst3;
            end
        end
        if (!rst && ival2 && (cnt2 == 0)) begin
            cnt2++;
            inst2_1 = inst2;
            pc2_1   = ipc2;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; rdy1 = 1'b0;
        manual1 = 1'b0; man_v1 = 1'b0; lat1 = 0;
        @(posedge clk); #1;
        cyc(); cyc();

        // Reset state
        chk("rst_valid", 64'(ival1), 64'd0);
        chk("rst_req", 64'(mreq1), 64'd1);
        chk("rst_addr", 64'(maddr1), 64'd0);

        // Zero-latency stream from RESET_PC, consumer always ready
        sb_reload(32'h0, 16);
        rdy1 = 1'b1;
        rst  = 1'b0;
        chk("m2_addr_beat0", 64'(maddr2), 64'd0);
        cyc();
        chk("m2_addr_beat1", 64'(maddr2), 64'd2);
        chk("addr_beat1", 64'(maddr1), 64'd1);
        cyc(); cyc();
        chk("valid_before_last", 64'(ival1), 64'd0);
        cyc();
        chk("first_valid", 64'(ival1), 64'd1);
        chk("first_inst", 64'(inst1), 64'h1122_3344);
        chk("first_pc", 64'(ipc1), 64'd0);
        repeat (8) cyc();
        lat1 = 2;
        for (int i = 0; i < 80 && pops1 < 4; i++) cyc();
        chk("stream_pops", 64'(pops1), 64'd4);

        // Fill the queue with the consumer stalled
        lat1 = 0; rdy1 = 1'b0;
        redir = 1'b1; redir_pc = 32'h0;
        cyc();
        redir = 1'b0;
        sb_reload(32'h0, 8);
        for (int i = 0; i < 40 && mreq1; i++) cyc();
        chk("full_req", 64'(mreq1), 64'd0);
        chk("full_addr", 64'(maddr1), 64'd16);
        chk("full_valid", 64'(ival1), 64'd1);
        repeat (3) cyc();
        chk("full_hold_req", 64'(mreq1), 64'd0);
        chk("full_head_pc", 64'(ipc1), 64'd0);
        rdy1 = 1'b1;
        cyc();
        rdy1 = 1'b0;
        chk("pop_req_back", 64'(mreq1), 64'd1);
        chk("pop_next_head", 64'(ipc1), 64'd4);
        for (int i = 0; i < 40 && mreq1; i++) cyc();
        chk("refill_addr", 64'(maddr1), 64'd20);

        // Pop and redirect together on a full queue
        rdy1 = 1'b1; redir = 1'b1; redir_pc = 32'h203;
        cyc();
        redir = 1'b0; rdy1 = 1'b0;
        chk("flush_valid", 64'(ival1), 64'd0);
        chk("flush_addr", 64'(maddr1), 64'h200);
        chk("flush_req", 64'(mreq1), 64'd1);

        // Redirect with a beat outstanding: stale beat is dropped
        rdy1 = 1'b1; redir = 1'b1; redir_pc = 32'h0;
        cyc();
        redir = 1'b0; manual1 = 1'b1; man_v1 = 1'b1;
        cyc();
        man_v1 = 1'b0;
        chk("beat1_addr", 64'(maddr1), 64'd1);
        cyc();
        chk("hold_addr", 64'(maddr1), 64'd1);
        redir = 1'b1; redir_pc = 32'h103;
        cyc();
        redir = 1'b0;
        chk("discard_req", 64'(mreq1), 64'd0);
        cyc(); cyc();
        chk("discard_wait_req", 64'(mreq1), 64'd0);
        man_v1 = 1'b1;
        cyc();
        man_v1 = 1'b0;
        chk("drop_req", 64'(mreq1), 64'd1);
        chk("drop_addr", 64'(maddr1), 64'h100);
        sb_reload(32'h100, 8);
        pops1 = 0; manual1 = 1'b0; lat1 = 1;
        for (int i = 0; i < 60 && pops1 < 2; i++) cyc();
        chk("redir_pops", 64'(pops1), 64'd2);

        // Side instances: 2-byte beats and PC wrap
        chk("m2_inst", 64'(inst2_1), 64'h1122_3344);
        chk("m2_pc", 64'(pc2_1), 64'd0);
        chk("wrap_pc1", 64'(pc3_1), 64'hFFFF_FFFC);
        chk("wrap_pc2", 64'(pc3_2), 64'd0);
        chk("wrap_inst2", 64'(inst3_2), 64'(exp_inst(32'h0)));

        // Reset beats a concurrent redirect with a beat outstanding
        manual1 = 1'b1; man_v1 = 1'b0;
        rst = 1'b1; redir = 1'b1; redir_pc = 32'h300;
        cyc();
        rst = 1'b0; redir = 1'b0;
        chk("rst_ovr_req", 64'(mreq1), 64'd1);
        chk("rst_ovr_addr", 64'(maddr1), 64'd0);
        chk("rst_ovr_valid", 64'(ival1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
